// File: rtl/ising_config.sv
// Shared GPIO host-bus layout and config-bank defaults used by every block
// that decodes the PS GPIO configuration bus.
package ising_config;

    localparam int GPIO_W        = 25;
    localparam int GPIO_WCLK_BIT = 24;
    localparam int GPIO_DATA_LSB = 16;
    localparam int GPIO_DATA_W   = 8;
    localparam int GPIO_ADDR_LSB = 0;
    localparam int GPIO_ADDR_W   = 16;

    localparam int CFG_REG_W    = 32;
    localparam int CFG_NUM_REGS = 64;
    localparam logic [63:0] CFG_TRIG_MASK_DFLT = 64'h7;

    // One extra bit so an address below the base shows up as a huge offset.
    function automatic logic [GPIO_ADDR_W:0] addr_offset(
        input logic [GPIO_ADDR_W-1:0] addr,
        input logic [GPIO_ADDR_W-1:0] base
    );
        return {1'b0, addr} - {1'b0, base};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// N-bit multi-stage synchroniser with rising-edge detect on one selected bit.
// sync_bus and wr_evt are aligned: wr_evt=1 means sync_bus is the sample that rose.
module gpio_sync_edge #(
    parameter int N           = 25,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_BIT    = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] bus_in,
    output logic [N-1:0] sync_bus,
    output logic         wr_evt
);

    logic [N-1:0]           r_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_fill;
    logic [N-1:0]           r_bus;
    logic                   r_bus_vld;
    logic                   r_evt;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) r_sync[gi] <= '0;
                    else      r_sync[gi] <= bus_in;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) r_sync[gi] <= '0;
                    else      r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    // r_fill tracks which stages hold real post-reset samples, so the zeroed
    // history cannot fake a rising edge when the bus is already high at release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill    <= '0;
            r_bus     <= '0;
            r_bus_vld <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            r_fill    <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_bus     <= r_sync[SYNC_STAGES-1];
            r_bus_vld <= r_fill[SYNC_STAGES-1];
            r_evt     <= r_bus_vld & r_fill[SYNC_STAGES-1]
                       & r_sync[SYNC_STAGES-1][EDGE_BIT] & ~r_bus[EDGE_BIT];
        end
    end

    assign sync_bus = r_bus;
    assign wr_evt   = r_evt;

endmodule

// File: rtl/gpio_cfg_regbank.sv
// GPIO-driven configuration register bank: byte-serial word assembly, trigger
// pulses for trigger addresses, write/bad counters and registered readback.
module gpio_cfg_regbank
    import ising_config::*;
#(
    parameter int                  NUM_REGS    = CFG_NUM_REGS,
    parameter int                  REG_W       = CFG_REG_W,
    parameter logic [15:0]         BASE_ADDR   = 16'h0,
    parameter logic [NUM_REGS-1:0] TRIG_MASK   = NUM_REGS'(CFG_TRIG_MASK_DFLT),
    parameter int                  SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [GPIO_W-1:0]         gpio_in,
    input  logic [GPIO_ADDR_W-1:0]    rd_addr,
    output logic [NUM_REGS*REG_W-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]       trig_pulse,
    output logic                      wr_strobe,
    output logic [REG_W-1:0]          rd_data,
    output logic [15:0]               wr_count,
    output logic [7:0]                bad_count
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [GPIO_ADDR_W:0] NUM_REGS_EXT = (GPIO_ADDR_W+1)'(NUM_REGS);

    logic [GPIO_W-1:0]      w_sync_bus;
    logic                   w_evt;
    logic [GPIO_ADDR_W-1:0] w_addr;
    logic [GPIO_DATA_W-1:0] w_data;
    logic                   w_wclk;
    logic [GPIO_ADDR_W:0]   w_wr_off;
    logic                   w_wr_in_range;
    logic [IDX_W-1:0]       w_wr_idx;
    logic                   w_wr_ok;
    logic                   w_wr_bad;
    logic [GPIO_ADDR_W:0]   w_rd_off;
    logic                   w_rd_in_range;
    logic [REG_W-1:0]       w_regs [NUM_REGS];
    logic [NUM_REGS-1:0]    w_trig_vec;

    logic                   r_wr_strobe;
    logic [15:0]            r_wr_count;
    logic [7:0]             r_bad_count;
    logic [REG_W-1:0]       r_rd_data;

    gpio_sync_edge #(
        .N           (GPIO_W),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_BIT    (GPIO_WCLK_BIT)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .bus_in   (gpio_in),
        .sync_bus (w_sync_bus),
        .wr_evt   (w_evt)
    );

    assign w_addr = w_sync_bus[GPIO_ADDR_LSB +: GPIO_ADDR_W];
    assign w_data = w_sync_bus[GPIO_DATA_LSB +: GPIO_DATA_W];
    assign w_wclk = w_sync_bus[GPIO_WCLK_BIT];

    assign w_wr_off      = addr_offset(w_addr, BASE_ADDR);
    assign w_wr_in_range = (w_wr_off < NUM_REGS_EXT);
    assign w_wr_idx      = w_wr_off[IDX_W-1:0];
    assign w_wr_ok       = w_evt & w_wclk & w_wr_in_range;
    assign w_wr_bad      = w_evt & w_wclk & ~w_wr_in_range;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic             w_hit;
            logic [REG_W-1:0] r_val;

            assign w_hit = w_wr_ok && (w_wr_idx == IDX_W'(gi));

            if (TRIG_MASK[gi]) begin : g_trig
                logic r_pulse;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_val   <= '0;
                        r_pulse <= 1'b0;
                    end else begin
                        r_pulse <= w_hit;
                        if (w_hit) r_val <= REG_W'(w_data);
                    end
                end
                assign w_trig_vec[gi] = r_pulse;
            end else begin : g_store
                // Bytes arrive MSB first; each write shifts the word up one byte.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_val <= '0;
                    end else if (w_hit) begin
                        if (REG_W == 8) r_val <= REG_W'(w_data);
                        else            r_val <= {r_val[REG_W-GPIO_DATA_W-1:0], w_data};
                    end
                end
                assign w_trig_vec[gi] = 1'b0;
            end

            assign w_regs[gi]                   = r_val;
            assign cfg_regs[gi*REG_W +: REG_W] = r_val;
        end
    endgenerate

    assign w_rd_off      = addr_offset(rd_addr, BASE_ADDR);
    assign w_rd_in_range = (w_rd_off < NUM_REGS_EXT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_strobe <= 1'b0;
            r_wr_count  <= '0;
            r_bad_count <= '0;
            r_rd_data   <= '0;
        end else begin
            r_wr_strobe <= w_wr_ok;
            if (w_wr_ok)
                r_wr_count <= r_wr_count + 16'd1;
            if (w_wr_bad && (r_bad_count != 8'hFF))
                r_bad_count <= r_bad_count + 8'd1;
            r_rd_data <= w_rd_in_range ? w_regs[w_rd_off[IDX_W-1:0]] : '0;
        end
    end

    assign trig_pulse = w_trig_vec;
    assign wr_strobe  = r_wr_strobe;
    assign wr_count   = r_wr_count;
    assign bad_count  = r_bad_count;
    assign rd_data    = r_rd_data;

endmodule
